// File: rtl/oled_i2c_pkg.sv
// Shared definitions for the OLED I2C write engine: FSM encoding, quarter
// phases, and the layout of the 3-byte write frame.
package oled_i2c_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [6:0] OLED_DEV_ADDR   = 7'h3C;
    localparam int         BYTES_PER_WRITE = 3;
    localparam logic [1:0] LAST_BYTE       = 2'(BYTES_PER_WRITE - 1);

    // Frame goes out MSB first: address+W, then control byte, then data byte.
    function automatic logic [23:0] pack_frame(input logic [6:0] dev,
                                               input logic [7:0] ctrl,
                                               input logic [7:0] data);
        return {dev, 1'b0, ctrl, data};
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider: counts 0..CLK_DIV-1 while enabled and flags the
// terminal count; held at zero when disabled or cleared.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: wrap on terminal count, park at zero when idle or cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (!en) begin
            cnt_d = 16'd0;
        end else if (cnt_q == TERM) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign tick = en & ~clr & (cnt_q == TERM);

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_i2c_writer.sv
// Single-master I2C write engine: sends address+W, control and data bytes for
// each accepted request and reports completion and any NACK.
module oled_i2c_writer
    import oled_i2c_pkg::*;
#(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = OLED_DEV_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_i2c_en,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       i2c_done,
    output logic       ack_err,
    output logic       busy,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);

    logic [2:0]  state_q,   state_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [2:0]  bit_q,     bit_d;
    logic [1:0]  byte_q,    byte_d;
    logic [23:0] shift_q,   shift_d;
    logic        nack_q,    nack_d;
    logic        ack_err_q, ack_err_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        scl_q,     scl_d;
    logic        sda_oe_q,  sda_oe_d;
    logic        accept_s;
    logic        tick_s;

    assign accept_s = (state_q == ST_IDLE) & write_i2c_en;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy_q),
        .clr   (accept_s),
        .tick  (tick_s)
    );

    // Sequencer: walks START, 8 bits + ACK per byte, STOP, DONE on quarter ticks.
    always_comb begin
        state_d   = state_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (write_i2c_en) begin
                    state_d   = ST_START;
                    quarter_d = Q0;
                    bit_d     = 3'd0;
                    byte_d    = 2'd0;
                    shift_d   = pack_frame(DEV_ADDR, reg_addr, reg_data);
                    nack_d    = 1'b0;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                if (!tick_s) begin
                    quarter_d = quarter_q;
                end else if (quarter_q == Q1) begin
                    state_d   = ST_BIT;
                    quarter_d = Q0;
                end else begin
                    quarter_d = quarter_q + 2'd1;
                end
            end
            ST_BIT: begin
                if (!tick_s) begin
                    quarter_d = quarter_q;
                end else if (quarter_q == Q3) begin
                    quarter_d = Q0;
                    shift_d   = {shift_q[22:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        state_d = ST_ACK;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    quarter_d = quarter_q + 2'd1;
                end
            end
            ST_ACK: begin
                if (!tick_s) begin
                    quarter_d = quarter_q;
                end else begin
                    case (quarter_q)
                        Q2: begin
                            nack_d    = sda_i;
                            quarter_d = Q3;
                        end
                        Q3: begin
                            quarter_d = Q0;
                            if (nack_q) begin
                                // A NACK abandons the remaining bytes.
                                ack_err_d = 1'b1;
                                state_d   = ST_STOP;
                            end else if (byte_q == LAST_BYTE) begin
                                state_d = ST_STOP;
                            end else begin
                                byte_d  = byte_q + 2'd1;
                                state_d = ST_BIT;
                            end
                        end
                        default: quarter_d = quarter_q + 2'd1;
                    endcase
                end
            end
            ST_STOP: begin
                if (!tick_s) begin
                    quarter_d = quarter_q;
                end else if (quarter_q == Q3) begin
                    state_d   = ST_DONE;
                    quarter_d = Q0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    quarter_d = quarter_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Pin levels follow the upcoming state/quarter so they register with it.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_START: begin
                scl_d    = 1'b1;
                sda_oe_d = (quarter_d == Q1);
            end
            ST_BIT: begin
                scl_d    = (quarter_d == Q1) | (quarter_d == Q2);
                sda_oe_d = ~shift_d[23];
            end
            ST_ACK: begin
                scl_d    = (quarter_d == Q1) | (quarter_d == Q2);
                sda_oe_d = 1'b0;
            end
            ST_STOP: begin
                scl_d    = (quarter_d != Q0);
                sda_oe_d = (quarter_d == Q0) | (quarter_d == Q1);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            quarter_q <= Q0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            shift_q   <= 24'd0;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign i2c_done = done_q;
    assign ack_err  = ack_err_q;
    assign busy     = busy_q;
    assign scl      = scl_q;
    assign sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_oled_i2c_writer.sv
// Self-checking bench: a bus-level I2C slave/monitor decodes the frames and
// the expected bytes, ACK levels and latencies come from the protocol rules.
module tb_oled_i2c_writer;

    localparam logic [7:0] ADDR_W = {7'h3C, 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       write_i2c_en = 1'b0;
    logic       en_slow = 1'b0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] reg_data = 8'd0;
    logic       i2c_done, ack_err, busy, scl, sda_oe, sda_i;
    logic       done_s, err_s, busy_s, scl_s, oe_s, sda_i_s;
    logic       slave_pull = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign sda_i   = !(sda_oe || slave_pull);
    assign sda_i_s = !oe_s;

    oled_i2c_writer #(.CLK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .write_i2c_en(write_i2c_en),
        .reg_addr(reg_addr), .reg_data(reg_data), .i2c_done(i2c_done),
        .ack_err(ack_err), .busy(busy), .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    oled_i2c_writer u_dut_slow (
        .clk(clk), .reset(reset), .write_i2c_en(en_slow),
        .reg_addr(reg_addr), .reg_data(reg_data), .i2c_done(done_s),
        .ack_err(err_s), .busy(busy_s), .scl(scl_s), .sda_oe(oe_s), .sda_i(sda_i_s)
    );

    // Bus monitor plus slave model: START/STOP detection, byte decode on SCL
    // rising edges, and ACK drive for every byte except index nack_at.
    int         nack_at = 3;
    logic       mon_scl_p = 1'b1;
    logic       mon_sda_p = 1'b1;
    bit         mon_in_frame = 1'b0;
    int         mon_bitcnt = 0;
    int         mon_byteidx = 0;
    logic [7:0] mon_sh = 8'd0;
    int         mon_starts = 0;
    int         mon_stops = 0;
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];

    always @(negedge clk) begin
        logic ln;
        ln = !(sda_oe || slave_pull);
        if (!reset) begin
            mon_in_frame = 1'b0;
            mon_bitcnt   = 0;
            slave_pull   = 1'b0;
        end else if (mon_scl_p && scl && (ln != mon_sda_p)) begin
            if (!ln) begin
                mon_starts++;
                mon_in_frame = 1'b1;
                mon_bitcnt   = 0;
                mon_byteidx  = 0;
            end else begin
                mon_stops++;
                mon_in_frame = 1'b0;
            end
        end else if (!mon_scl_p && scl && mon_in_frame) begin
            if (mon_bitcnt < 8) begin
                mon_sh = {mon_sh[6:0], ln};
                mon_bitcnt++;
            end else begin
                mon_bytes.push_back(mon_sh);
                mon_acks.push_back(ln);
                mon_bitcnt = 0;
                mon_byteidx++;
            end
        end else if (mon_scl_p && !scl && mon_in_frame) begin
            slave_pull = (mon_bitcnt == 8) && (mon_byteidx != nack_at);
        end
        mon_scl_p = scl;
        mon_sda_p = !(sda_oe || slave_pull);
    end

    // Reference: bytes on the wire and quarter count follow from where the NACK lands.
    function automatic int exp_nbytes(input int nk);
        return (nk < 3) ? nk + 1 : 3;
    endfunction

    function automatic int exp_latency(input int nk, input int div);
        return (2 + 36 * exp_nbytes(nk) + 4) * div;
    endfunction

    // Issue one request on the fast DUT and wait for i2c_done; an optional
    // second request pulse is fired req2 cycles after acceptance.
    task automatic run_write(input logic [7:0] a, input logic [7:0] d, input int req2,
                             output int lat, output logic busy_acc, output logic err_acc,
                             output logic err_done, output bit tmo);
        @(posedge clk); #1;
        write_i2c_en = 1'b1; reg_addr = a; reg_data = d;
        @(posedge clk); #1;
        write_i2c_en = 1'b0;
        busy_acc = busy; err_acc = ack_err; err_done = 1'bx;
        lat = 0; tmo = 1'b1;
        while (lat < 20000) begin
            write_i2c_en = (req2 > 0) && (lat + 1 == req2);
            reg_addr = write_i2c_en ? ~a : a;
            @(posedge clk); lat++; #1;
            if (i2c_done) begin
                err_done = ack_err; tmo = 1'b0;
                break;
            end
        end
        write_i2c_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec += 6;
        if (scl !== 1'b1)      begin n_err++; $display("FAIL reset_scl got %b want 1", scl); end
        if (sda_oe !== 1'b0)   begin n_err++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        if (i2c_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", i2c_done); end
        if (ack_err !== 1'b0)  begin n_err++; $display("FAIL reset_ack_err got %b want 0", ack_err); end
        if (scl_s !== 1'b1)    begin n_err++; $display("FAIL reset_scl_slow got %b want 1", scl_s); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_write();
        int lat, base, st0, sp0; logic ba, ea, ed; bit tmo;
        logic [7:0] exp_b [3];
        nack_at = 3; base = mon_bytes.size(); st0 = mon_starts; sp0 = mon_stops;
        exp_b = '{ADDR_W, 8'h00, 8'hAE};
        run_write(8'h00, 8'hAE, 0, lat, ba, ea, ed, tmo);
        n_vec += 6;
        if (tmo)                 begin n_err++; $display("FAIL full_timeout got timeout want done"); end
        if (lat != 456)          begin n_err++; $display("FAIL full_latency got %0d want 456", lat); end
        if (ba !== 1'b1)         begin n_err++; $display("FAIL full_busy got %b want 1", ba); end
        if (ed !== 1'b0)         begin n_err++; $display("FAIL full_ack_err got %b want 0", ed); end
        if (mon_bytes.size() - base != 3) begin n_err++; $display("FAIL full_nbytes got %0d want 3", mon_bytes.size() - base); end
        if (mon_starts - st0 != 1 || mon_stops - sp0 != 1) begin
            n_err++; $display("FAIL full_start_stop got %0d/%0d want 1/1", mon_starts - st0, mon_stops - sp0);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (base + i >= mon_bytes.size() || mon_bytes[base + i] !== exp_b[i] || mon_acks[base + i] !== 1'b0) begin
                n_err++; $display("FAIL full_byte%0d got %h want %h (acked)", i,
                                  (base + i < mon_bytes.size()) ? mon_bytes[base + i] : 8'hxx, exp_b[i]);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (i2c_done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b want 0", i2c_done); end
    endtask

    task automatic test_addr_nack();
        int lat, base; logic ba, ea, ed; bit tmo;
        nack_at = 0; base = mon_bytes.size();
        run_write(8'($urandom), 8'($urandom), 0, lat, ba, ea, ed, tmo);
        n_vec += 4;
        if (lat != 168 || tmo)   begin n_err++; $display("FAIL nack_latency got %0d want 168", lat); end
        if (ed !== 1'b1)         begin n_err++; $display("FAIL nack_ack_err got %b want 1", ed); end
        if (mon_bytes.size() - base != 1) begin n_err++; $display("FAIL nack_nbytes got %0d want 1", mon_bytes.size() - base); end
        else if (mon_bytes[base] !== ADDR_W || mon_acks[base] !== 1'b1) begin
            n_err++; $display("FAIL nack_byte0 got %h/%b want %h/1", mon_bytes[base], mon_acks[base], ADDR_W);
        end
        repeat (50) @(posedge clk);
        #1;
        if (ack_err !== 1'b1) begin n_err++; $display("FAIL nack_err_hold got %b want 1", ack_err); end
    endtask

    task automatic test_busy_request();
        int lat, base, st0, extra; logic ba, ea, ed; bit tmo;
        logic [7:0] a, d;
        a = 8'($urandom); d = 8'($urandom);
        nack_at = 3; base = mon_bytes.size(); st0 = mon_starts;
        run_write(a, d, 100, lat, ba, ea, ed, tmo);
        n_vec += 4;
        if (ea !== 1'b0) begin n_err++; $display("FAIL accept_clears_ack_err got %b want 0", ea); end
        if (lat != 456 || tmo) begin n_err++; $display("FAIL busy_req_latency got %0d want 456", lat); end
        if (mon_bytes.size() - base != 3) begin n_err++; $display("FAIL busy_req_nbytes got %0d want 3", mon_bytes.size() - base); end
        else if (mon_bytes[base + 1] !== a || mon_bytes[base + 2] !== d) begin
            n_err++; $display("FAIL busy_req_bytes got %h %h want %h %h", mon_bytes[base + 1], mon_bytes[base + 2], a, d);
        end
        extra = 0;
        repeat (600) begin @(posedge clk); #1; if (i2c_done) extra++; end
        n_vec += 2;
        if (extra != 0) begin n_err++; $display("FAIL busy_req_extra_done got %0d want 0", extra); end
        if (mon_starts - st0 != 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL busy_req_frames got %0d busy %b want 1 busy 0", mon_starts - st0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, base, st0, extra; logic ba, ea, ed; bit tmo;
        logic [7:0] a, d;
        a = 8'($urandom); d = 8'($urandom); nack_at = 3;
        @(posedge clk); #1;
        write_i2c_en = 1'b1; reg_addr = a; reg_data = d;
        @(posedge clk); #1;
        write_i2c_en = 1'b0;
        repeat (199) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_vec += 4;
        if (scl !== 1'b1)      begin n_err++; $display("FAIL midreset_scl got %b want 1", scl); end
        if (sda_oe !== 1'b0)   begin n_err++; $display("FAIL midreset_sda_oe got %b want 0", sda_oe); end
        if (busy !== 1'b0)     begin n_err++; $display("FAIL midreset_busy got %b want 0", busy); end
        if (i2c_done !== 1'b0) begin n_err++; $display("FAIL midreset_done got %b want 0", i2c_done); end
        extra = 0;
        repeat (600) begin @(posedge clk); #1; if (i2c_done) extra++; end
        n_vec++;
        if (extra != 0) begin n_err++; $display("FAIL midreset_stray_done got %0d want 0", extra); end
        base = mon_bytes.size(); st0 = mon_starts;
        run_write(d, a, 0, lat, ba, ea, ed, tmo);
        n_vec += 2;
        if (lat != 456 || tmo || ed !== 1'b0) begin n_err++; $display("FAIL postreset_write got lat %0d err %b want 456 0", lat, ed); end
        if (mon_bytes.size() - base != 3 || mon_starts - st0 != 1) begin
            n_err++; $display("FAIL postreset_frame got %0d bytes %0d starts want 3 1", mon_bytes.size() - base, mon_starts - st0);
        end else if (mon_bytes[base + 1] !== d || mon_bytes[base + 2] !== a) begin
            n_err++; $display("FAIL postreset_bytes got %h %h want %h %h", mon_bytes[base + 1], mon_bytes[base + 2], d, a);
        end
    endtask

    // Back-to-back writes (optionally with random NACK position) against the reference.
    task automatic test_back_to_back(input int count, input bit rand_nack);
        int lat, base, st0, sp0, dones, nb; logic ba, ea, ed; bit tmo;
        logic [7:0] exp_b [3];
        st0 = mon_starts; sp0 = mon_stops; dones = 0;
        for (int t = 0; t < count; t++) begin
            nack_at = rand_nack ? int'($urandom_range(0, 3)) : 3;
            exp_b = '{ADDR_W, 8'($urandom), 8'($urandom)};
            nb = exp_nbytes(nack_at);
            base = mon_bytes.size();
            run_write(exp_b[1], exp_b[2], 0, lat, ba, ea, ed, tmo);
            if (!tmo) dones++;
            n_vec += 3;
            if (lat != exp_latency(nack_at, 4) || tmo) begin
                n_err++; $display("FAIL b2b%0d_latency got %0d want %0d", t, lat, exp_latency(nack_at, 4));
            end
            if (ea !== 1'b0 || ed !== (nack_at < 3)) begin
                n_err++; $display("FAIL b2b%0d_ack_err got %b/%b want 0/%b", t, ea, ed, nack_at < 3);
            end
            if (mon_bytes.size() - base != nb) begin
                n_err++; $display("FAIL b2b%0d_nbytes got %0d want %0d", t, mon_bytes.size() - base, nb);
            end else begin
                for (int i = 0; i < nb; i++) begin
                    n_vec++;
                    if (mon_bytes[base + i] !== exp_b[i] || mon_acks[base + i] !== (i == nack_at)) begin
                        n_err++; $display("FAIL b2b%0d_byte%0d got %h/%b want %h/%b", t, i,
                                          mon_bytes[base + i], mon_acks[base + i], exp_b[i], i == nack_at);
                    end
                end
            end
        end
        n_vec += 2;
        if (dones != count) begin n_err++; $display("FAIL b2b_done_count got %0d want %0d", dones, count); end
        if (mon_starts - st0 != count || mon_stops - sp0 != count) begin
            n_err++; $display("FAIL b2b_scl_high_sda_edges got %0d/%0d want %0d/%0d",
                              mon_starts - st0, mon_stops - sp0, count, count);
        end
    endtask

    task automatic test_default_timing();
        int runs[$]; int runlen, cyc; logic lvl; bit got_done;
        @(posedge clk); #1 en_slow = 1'b1;
        @(posedge clk); #1 en_slow = 1'b0;
        lvl = scl_s; runlen = 1; cyc = 0; got_done = 1'b0;
        while (cyc < 8000) begin
            @(posedge clk); cyc++; #1;
            if (done_s) begin got_done = 1'b1; break; end
            if (scl_s === lvl) runlen++;
            else begin runs.push_back(runlen); lvl = scl_s; runlen = 1; end
        end
        n_vec += 3;
        if (!got_done || cyc != exp_latency(0, 125)) begin
            n_err++; $display("FAIL slow_latency got %0d want %0d", cyc, exp_latency(0, 125));
        end
        if (err_s !== 1'b1) begin n_err++; $display("FAIL slow_ack_err got %b want 1", err_s); end
        if (runs.size() < 17) begin n_err++; $display("FAIL slow_runs got %0d want >=17", runs.size()); end
        else begin
            if (runs[1] != 125) begin n_err++; $display("FAIL slow_first_low got %0d want 125", runs[1]); end
            for (int k = 2; k <= 16; k++) begin
                n_vec++;
                if (runs[k] != 250) begin
                    n_err++; $display("FAIL slow_scl_%s_run%0d got %0d want 250", (k % 2 == 0) ? "high" : "low", k, runs[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_addr_nack();
        test_busy_request();
        test_reset_mid();
        test_back_to_back(28, 1'b0);
        test_back_to_back(8, 1'b1);
        test_default_timing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
